// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch stage: FSM encoding,
// queue entry layout and the default sizing parameters.
package fetch_queue_pkg;

  localparam int          INST_W        = 32;
  localparam int          QDEPTH_DEF    = 4;
  localparam int          MAX_OUTST_DEF = 2;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_inst_queue.sv
// Synchronous FIFO of {pc, inst} entries. Flush wins over push and pop;
// push while full is accepted only together with a pop.
module fetch_queue_inst_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fq_entry_t        wdata,
  output fq_entry_t        rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    do_push  = push & (~full | pop);
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; rdata is forced to zero while empty so stale contents never leak.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order memory requests under a
// credit rule, buffers returned words and drops stale ones after a redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          QDEPTH    = QDEPTH_DEF,
  parameter int          MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fd_valid,
  input  logic              fd_ready,
  output logic [INST_W-1:0] fd_inst,
  output logic [31:0]       fd_pc
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  resp_pc_q, resp_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;

  logic          grant, keep, q_push, q_pop, q_flush, q_full, q_empty;
  logic [CW-1:0] q_count;
  fq_entry_t     q_wdata, q_rdata;

  fetch_queue_inst_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (q_flush),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign imem_addr = fetch_pc_q;
  assign fd_valid  = ~q_empty;
  assign fd_pc     = q_rdata.pc;
  assign fd_inst   = q_rdata.inst;

  always_comb begin
    // Credit rule: queued plus in-flight words never exceed the queue depth.
    imem_req = (state_q != FETCH_BOOT) && !redirect_valid
            && (int'(outst_q) < MAX_OUTST) && !q_full
            && ((int'(q_count) + int'(outst_q)) < QDEPTH);
    grant    = imem_req & imem_gnt;
    keep     = imem_rvalid && (drop_cnt_q == '0) && !redirect_valid;

    q_push   = keep;
    q_pop    = fd_valid & fd_ready & ~redirect_valid;
    q_flush  = redirect_valid;
    q_wdata  = '{pc: resp_pc_q, inst: imem_rdata};

    outst_d    = outst_q + OW'(grant) - OW'(imem_rvalid);
    fetch_pc_d = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = keep  ? resp_pc_q  + 32'd4 : resp_pc_q;
    drop_cnt_d = (imem_rvalid && drop_cnt_q != '0) ? drop_cnt_q - OW'(1) : drop_cnt_q;

    // No grant is possible in a redirect cycle, so outst_d already counts every stale request.
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      drop_cnt_d = outst_d;
    end

    if (state_q == FETCH_BOOT) state_d = FETCH_RUN;
    else                       state_d = (drop_cnt_d != '0) ? FETCH_DRAIN : FETCH_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with variable latency plus a
// program-order model of the PC/instruction stream decode must observe.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          QD  = 4;
  localparam int          MO  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              fd_valid;
  logic              fd_ready;
  logic [INST_W-1:0] fd_inst;
  logic [31:0]       fd_pc;

  fetch_queue #(.RESET_PC(RPC), .QDEPTH(QD), .MAX_OUTST(MO)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fd_valid       (fd_valid),
    .fd_ready       (fd_ready),
    .fd_inst        (fd_inst),
    .fd_pc          (fd_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          vectors = 0, miscompares = 0, cyc = 0;
  int          gnt_pct = 100, lat_min = 1, lat_max = 1, rv_pct = 100;
  logic [31:0] exp_pc, req_exp, prev_pc, prev_inst, hs_pc;
  logic        prev_hold, prev_redir, hs_seen;
  int          hs_count = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after the rising edge, check and update the model at the falling edge.
  task automatic step(input logic r, input logic redir, input logic [31:0] rpc, input logic rdy);
    logic rv;
    @(posedge clk);
    #1;
    cyc++;
    rst            = r;
    redirect_valid = redir;
    redirect_pc    = rpc;
    fd_ready       = rdy;
    imem_gnt       = ($urandom_range(99) < gnt_pct);
    rv = !r && (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(99) < rv_pct);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend[0].addr) : $urandom;
    @(negedge clk);
    hs_seen = 1'b0;
    if (r) begin
      pend.delete();
      exp_pc     = RPC;
      req_exp    = RPC;
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
    end else begin
      chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
      if (prev_redir) chk("valid_after_redirect", 32'(fd_valid), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(fd_valid), 32'd1);
        chk("hold_pc", fd_pc, prev_pc);
        chk("hold_inst", fd_inst, prev_inst);
      end
      if (fd_valid) begin
        chk("head_pc", fd_pc, exp_pc);
        chk("head_inst", fd_inst, mem_word(exp_pc));
      end
      if (redir) chk("req_on_redirect", 32'(imem_req), 32'd0);
      if (imem_req) chk("credit", 32'(pend.size() < MO), 32'd1);
      if (rv) void'(pend.pop_front());
      if (imem_req && imem_gnt) begin
        chk("grant_addr", imem_addr, req_exp);
        req_exp = req_exp + 32'd4;
        pend.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      end
      if (fd_valid && rdy && !redir) begin
        hs_seen = 1'b1;
        hs_pc   = fd_pc;
        hs_count++;
        exp_pc  = exp_pc + 32'd4;
      end
      if (redir) begin
        exp_pc  = {rpc[31:2], 2'b00};
        req_exp = {rpc[31:2], 2'b00};
      end
      prev_hold  = fd_valid && !rdy && !redir;
      prev_pc    = fd_pc;
      prev_inst  = fd_inst;
      prev_redir = redir;
    end
  endtask

  task automatic wait_hs(input string tag);
    int w = 0;
    step(1'b0, 1'b0, 32'd0, 1'b1);
    while (!hs_seen && w < 60) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      w++;
    end
    chk(tag, 32'(hs_seen), 32'd1);
  endtask

  task automatic wait_two_outst(input string tag);
    int w = 0;
    while (!(pend.size() == MO && pend[0].due > cyc + 1) && w < 40) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      w++;
    end
    chk(tag, 32'(w < 40), 32'd1);
  endtask

  initial begin
    int          n, hs0;
    logic        rd;
    logic [31:0] rp;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; fd_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset values and fetch start
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_fd_valid", 32'(fd_valid), 32'd0);
    chk("rst_fd_inst", fd_inst, 32'd0);
    chk("rst_fd_pc", fd_pc, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("boot_no_req", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RPC);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("fill_no_valid", 32'(fd_valid), 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("first_valid", 32'(fd_valid), 32'd1);
    chk("first_pc", fd_pc, RPC);

    // Back-to-back streaming with single-cycle memory
    n = 0;
    repeat (20) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      if (fd_valid) n++;
    end
    chk("streaming", 32'(n), 32'd20);

    // Back-pressure fills the queue exactly, then drains in order
    repeat (10) step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("full_no_req", 32'(imem_req), 32'd0);
    chk("full_outst", 32'(pend.size()), 32'd0);
    chk("full_valid", 32'(fd_valid), 32'd1);
    gnt_pct = 0;
    n = 0;
    repeat (8) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      if (hs_seen) n++;
    end
    chk("drain_count", 32'(n), 32'(QD));
    chk("drained_empty", 32'(fd_valid), 32'd0);
    gnt_pct = 100;

    // Redirect with two responses outstanding
    lat_min = 3; lat_max = 3;
    wait_two_outst("redir1_setup");
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("redir1_addr", imem_addr, 32'h0000_0100);
    wait_hs("redir1_timeout");
    chk("redir1_first_pc", hs_pc, 32'h0000_0100);

    // Redirect colliding with a response and a pop
    lat_min = 1; lat_max = 1;
    repeat (8) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    chk("redir2_collision", 32'(fd_valid & imem_rvalid), 32'd1);
    wait_hs("redir2_timeout");
    chk("redir2_first_pc", hs_pc, 32'h0000_0200);

    // Second redirect while still draining stale responses
    lat_min = 3; lat_max = 3;
    wait_two_outst("redir3_setup");
    step(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    chk("redir3_stale_pending", 32'(pend.size() > 0), 32'd1);
    wait_hs("redir3_timeout");
    chk("redir3_first_pc", hs_pc, 32'h0000_0400);

    // Address wrap at the top of the address space
    lat_min = 1; lat_max = 2;
    step(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1);
    n = 0;
    while (!(hs_seen && hs_pc == 32'd0) && n < 60) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      n++;
    end
    chk("wrap_reached_zero", 32'(n < 60), 32'd1);

    // Reset in mid-operation
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    chk("rst2_fd_valid", 32'(fd_valid), 32'd0);
    chk("rst2_req", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("rst2_first_req", 32'(imem_req), 32'd1);
    chk("rst2_first_addr", imem_addr, RPC);

    // Randomized traffic: grants, latency, response gaps, back-pressure, redirects
    gnt_pct = 70; lat_min = 1; lat_max = 4; rv_pct = 70;
    hs0 = hs_count;
    repeat (3000) begin
      rd = ($urandom_range(99) < 2);
      rp = $urandom;
      step(1'b0, rd, rp, ($urandom_range(99) < 70));
    end
    chk("random_progress", 32'((hs_count - hs0) > 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage directly upstream of the decoder. It owns the fetch PC and issues in-order requests to instruction memory. Returned words are buffered with their PCs in a small queue and presented to decode through a valid/ready handshake. A redirect from branch/jump resolution flushes the queue, discards stale in-flight responses and restarts fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QDEPTH, 4, queue entries (power of 2, ≥2)
- MAX_OUTST, 2, maximum granted-but-unanswered memory requests (1..QDEPTH)

Ports:
- clk  in  1  Clock. One clock domain; all logic is on the rising edge.
- rst  in  1  Reset. Synchronous and active-high.
- imem_req  out  1  fetch request
- imem_addr  out  32  word-aligned fetch address, bits [1:0] always 0
- imem_gnt  in  1  request accepted this cycle; only meaningful while imem_req=1
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant
- imem_rdata  in  `INST_BUS  instruction word
- redirect_valid  in  1  flush and restart
- redirect_pc  in  32  restart address; bits [1:0] ignored
- fd_valid  out  1  queue head valid to decode
- fd_ready  in  1  decode accepts head
- fd_inst  out  `INST_BUS  head instruction
- fd_pc  out  32  head PC

## Operation
- Registers:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next response to be kept.
  - outst: 0..MAX_OUTST.
  - drop_cnt: 0..MAX_OUTST.
  - Queue with count 0..QDEPTH.
- FSM states:
  - BOOT: entered on reset. Lasts one cycle; no request.
  - RUN: drop_cnt=0.
  - DRAIN: drop_cnt>0.
- FSM transitions:
  - BOOT→RUN unconditionally.
  - RUN→DRAIN on a redirect with outst_next>0.
  - DRAIN→RUN when the last stale response is dropped and no redirect occurs.
- Request condition: imem_req = state≠BOOT & ~redirect_valid & outst<MAX_OUTST & (count+outst)<QDEPTH. This credit rule guarantees the queue never overflows.
- Request/address behaviour:
  - imem_addr = fetch_pc.
  - On req&gnt, fetch_pc += 4 (wraps modulo 2^32) and outst += 1.
  - A request not yet granted may be withdrawn on redirect; memory must tolerate this.
- Response handling:
  - On rvalid, outst -= 1.
  - If drop_cnt>0: word discarded, drop_cnt -= 1.
  - Otherwise: push {resp_pc, imem_rdata} and resp_pc += 4.
- Pop: on fd_valid&fd_ready.
- Simultaneous push and pop are legal at any occupancy, including full.
- Redirect (has priority over every other event in the same cycle):
  - Queue cleared; any pop that cycle is void.
  - fetch_pc ← resp_pc ← {redirect_pc[31:2],2'b00}.
  - No grant is taken that cycle.
  - outst_next = outst − rvalid.
  - drop_cnt ← outst_next.
  - A response arriving in the redirect cycle is dropped.
- Redirect while in DRAIN: drop_cnt is reloaded with outst_next, which already counts every stale request.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, fd_valid=0, fd_inst=0, fd_pc=0.
  - outst=drop_cnt=count=0, state=BOOT.
- Fetch start: first imem_req rises in the second cycle after rst deasserts.
- Queue is registered, with no bypass. A response kept in cycle t gives fd_valid=1 at t+1.
- Minimum grant-to-decode latency is 2 cycles.
- fd_valid/fd_inst/fd_pc come straight from the head entry. They hold stable while fd_valid&~fd_ready, unless a redirect occurs.
- Redirect in cycle t:
  - fd_valid=0 at t+1.
  - imem_req may assert at t+1 with imem_addr=redirect PC.
  - The first new word reaches decode no earlier than t+3.
- rst mid-operation: all state is re-initialised next edge. Responses to pre-reset requests are the memory's responsibility and are not tracked.

## Structure
- def.vh additions:
  - FETCH_BOOT / FETCH_RUN / FETCH_DRAIN state encodings (2 bits).
  - QDEPTH and MAX_OUTST defaults.
- Sub-module INST_QUEUE: a synchronous FIFO of {pc, inst}.
  - Ports: push, pop, flush, full, empty, count.
  - Pointer wrap modulo QDEPTH.
  - flush has priority over push and pop.
- Top level holds the FSM, PC registers, outst and drop counters.

## Test plan
- Reset, 1-cycle-latency memory, fd_ready=1 → fd_pc sequence 0,4,8,12…, one instruction per cycle after a 3-cycle fill, no gaps.
- fd_ready=0 for 10 cycles → exactly QDEPTH entries buffered, outst=0, imem_req=0. fd_ready=1 then drains 4 entries in order before new data.
- Redirect to 32'h0000_0103 with 2 responses outstanding:
  - Next fetch address is 0x100.
  - Both stale words are dropped.
  - The first word kept is the one for 0x100, shown with fd_pc=0x100.
- Redirect in the same cycle as rvalid and fd_ready → that word neither enters the queue nor counts as consumed; drop_cnt=outst−1.
- Second redirect during DRAIN → only the newest target's words appear; no stale word leaks.
- fetch_pc=32'hFFFF_FFFC → next request address 0, fd_pc wraps correctly.
